// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer ahead of the bit-serial scrambler: sync word (bypassed),
// one-cycle seed load, then MSB-first scrambled payload bytes and a done pulse.
module scrambler_frame_ctrl #(
    parameter int                 SYNC_W    = 16,
    parameter logic [SYNC_W-1:0]  SYNC_WORD = 16'hF628,
    parameter int                 SEED_W    = 7,
    parameter logic [SEED_W-1:0]  SEED      = 7'h7F,
    parameter int                 LEN_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              scr_bypass,
    output logic              scr_en,
    output logic              scr_load,
    output logic [SEED_W-1:0] scr_seed,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int IDX_W = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LOAD,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [2:0]         bcnt_q, bcnt_d;
    logic               full_q, full_d;
    logic               underrun_q, underrun_d;

    logic               owed;
    logic               last_bit;
    logic               ready_int;
    logic               accept;

    // rem_q counts bytes still to be fetched, so "owed" is fetched < N.
    assign owed      = (rem_q != '0);
    assign last_bit  = full_q && (bcnt_q == 3'd0);
    assign ready_int = (state_q == S_LOAD) ||
                       ((state_q == S_PAYLOAD) && (!full_q || last_bit) && owed);
    assign accept    = din_valid && ready_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            rem_q      <= '0;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        shreg_d    = shreg_q;
        bcnt_d     = bcnt_q;
        full_d     = full_q;
        underrun_d = underrun_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d      = frame_len;
                    underrun_d = 1'b0;
                    full_d     = 1'b0;
                    idx_d      = IDX_W'(SYNC_W - 1);
                    state_d    = S_SYNC;
                end
            end
            S_SYNC: begin
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = owed ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (full_q) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    bcnt_d  = bcnt_q - 3'd1;
                    if (last_bit) begin
                        full_d = 1'b0;
                        if (!owed) begin
                            state_d = S_DONE;
                        end
                    end
                end else if (owed && !din_valid) begin
                    underrun_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A byte accepted on the last bit refills the register with no gap.
        if (accept) begin
            shreg_d = din;
            bcnt_d  = 3'd7;
            full_d  = 1'b1;
            rem_d   = rem_q - 1'b1;
        end
    end

    always_comb begin
        bit_out    = 1'b0;
        bit_valid  = 1'b0;
        scr_bypass = 1'b0;
        scr_en     = 1'b0;
        scr_load   = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_SYNC: begin
                bit_out    = SYNC_WORD[idx_q];
                bit_valid  = 1'b1;
                scr_bypass = 1'b1;
            end
            S_LOAD: begin
                scr_load = 1'b1;
            end
            S_PAYLOAD: begin
                if (full_q) begin
                    bit_out   = shreg_q[7];
                    bit_valid = 1'b1;
                    scr_en    = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign din_ready = ready_int;
    assign underrun  = underrun_q;
    assign scr_seed  = SEED;

endmodule
